// File: rtl/compat_trig_latch.sv
// compat_trig_latch
// Turns the 40 MHz-compatible ToTd trigger level into single accepted events,
// holds each event pending until readout acknowledges it, then applies a
// programmable hold-off measured in 40 MHz ticks. Also maintains the
// slow-control counters: total accepts, accepts per PPS second, and drops.
module compat_trig_latch #(
   parameter int CNT_BITS  = 24,
   parameter int RATE_BITS = 16
) (
   input  logic                 CLK120,
   input  logic                 RESET,
   input  logic [1:0]           ENABLE40,
   input  logic                 TRIG_IN,
   input  logic                 TRIG_MASK,
   input  logic [15:0]          HOLDOFF,
   input  logic                 TRIG_ACK,
   input  logic                 PPS,
   output logic                 TRIG_OUT,
   output logic                 TRIG_PENDING,
   output logic                 BUSY,
   output logic [CNT_BITS-1:0]  TRIG_COUNT,
   output logic [RATE_BITS-1:0] RATE,
   output logic [RATE_BITS-1:0] DROPPED
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_HOLDOFF
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [15:0]          ho_cnt;
   logic [15:0]          ho_cnt_next;
   logic                 trig_d;
   logic                 pps_d;
   logic                 trig_edge;
   logic                 pps_edge;
   logic                 accept;
   logic                 drop;
   logic [RATE_BITS-1:0] acc;
   logic [RATE_BITS-1:0] acc_inc;

   assign trig_edge = TRIG_IN & ~trig_d;
   assign pps_edge  = PPS & ~pps_d;

   // Accumulator value including an accept on this cycle, pinned at all-ones.
   assign acc_inc = (accept && (acc != '1)) ? acc + RATE_BITS'(1) : acc;

   // Delayed copies for edge detection; they come out of reset high so a level already high is not seen as an edge.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         trig_d <= 1'b1;
         pps_d  <= 1'b1;
      end else begin
         trig_d <= TRIG_IN;
         pps_d  <= PPS;
      end
   end

   // State register and hold-off tick counter.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state  <= ST_IDLE;
         ho_cnt <= '0;
      end else begin
         state  <= state_next;
         ho_cnt <= ho_cnt_next;
      end
   end

   // Next-state logic: accept in IDLE, wait for acknowledge, then count down 40 MHz ticks.
   always_comb begin
      state_next  = state;
      ho_cnt_next = ho_cnt;
      accept      = 1'b0;
      drop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig_edge && TRIG_MASK) begin
               accept     = 1'b1;
               state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            drop = trig_edge & TRIG_MASK;
            if (TRIG_ACK) begin
               if (HOLDOFF == 16'd0) begin
                  state_next = ST_IDLE;
               end else begin
                  ho_cnt_next = HOLDOFF;
                  state_next  = ST_HOLDOFF;
               end
            end
         end
         ST_HOLDOFF: begin
            drop = trig_edge & TRIG_MASK;
            if (ENABLE40 == 2'd0) begin
               if (ho_cnt <= 16'd1) begin
                  ho_cnt_next = '0;
                  state_next  = ST_IDLE;
               end else begin
                  ho_cnt_next = ho_cnt - 16'd1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered status flags and slow-control counters; RATE snapshots the accumulator on each PPS edge.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         TRIG_OUT     <= 1'b0;
         TRIG_PENDING <= 1'b0;
         BUSY         <= 1'b0;
         TRIG_COUNT   <= '0;
         RATE         <= '0;
         DROPPED      <= '0;
         acc          <= '0;
      end else begin
         TRIG_OUT     <= accept;
         TRIG_PENDING <= (state_next == ST_PENDING);
         BUSY         <= (state_next != ST_IDLE);
         if (accept) begin
            TRIG_COUNT <= TRIG_COUNT + CNT_BITS'(1);
         end
         if (drop && (DROPPED != '1)) begin
            DROPPED <= DROPPED + RATE_BITS'(1);
         end
         if (pps_edge) begin
            RATE <= acc_inc;
            acc  <= '0;
         end else begin
            acc  <= acc_inc;
         end
      end
   end

endmodule
